// File: rtl/brent_kung_sweep_if.sv
// Operand/sum bus between the sweep engine and the adder under test.
//   master (sweep engine): drives a_out/b_out, receives sum_in
//   slave  (adder)       : receives a_out/b_out, drives sum_in
interface brent_kung_sweep_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic [WIDTH:0]   sum_in;

  modport master (output a_out, output b_out, input sum_in);
  modport slave  (input a_out, input b_out, output sum_in);
endinterface

// File: rtl/brent_kung_sweep.sv
// On-chip stimulus generator and response checker for the brent_kung adder.
// Sweeps every (a, b) operand pair, waits SETTLE cycles per vector, then
// compares the adder sum with a+b and records mismatches.
//
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   start       level-sampled sweep request (ignored while busy)
//   adder       operand/sum bus (master side): a_out, b_out -> adder, sum_in <- adder
//   busy        sweep in progress
//   done        sweep finished; held until next start or reset
//   pass        done with zero mismatches
//   err_count   saturating mismatch count
//   fail_valid  fail_a/fail_b hold the first mismatching operand pair
//   fail_a/b    operands of the first mismatch
//
// Optional build macro BRENT_KUNG_SWEEP_INJECT_EN adds input 'inject', which
// flips bit 0 of the expected sum during CHECK to self-test the comparator.
module brent_kung_sweep #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
`ifdef BRENT_KUNG_SWEEP_INJECT_EN
  input  logic                 inject,
`endif
  brent_kung_sweep_if.master   adder,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [7:0]           err_count,
  output logic                 fail_valid,
  output logic [WIDTH-1:0]     fail_a,
  output logic [WIDTH-1:0]     fail_b
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned ERR_W = 8;
  localparam logic [WIDTH-1:0] VEC_MAX = '1;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             fv_q, fv_d;
  logic [WIDTH-1:0] fa_q, fa_d;
  logic [WIDTH-1:0] fb_q, fb_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic [WIDTH:0]   exp_c;
  logic             mismatch_c;

  // Reference sum, full WIDTH+1 bits so the carry is checked too
  always_comb begin
    exp_c = {1'b0, a_q} + {1'b0, b_q};
`ifdef BRENT_KUNG_SWEEP_INJECT_EN
    if (inject) begin
      exp_c[0] = ~exp_c[0];
    end
`endif
    mismatch_c = (adder.sum_in != exp_c);
  end

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fv_d    = fv_q;
    fa_d    = fa_q;
    fb_d    = fb_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = APPLY;
          a_d     = '0;
          b_d     = '0;
          cnt_d   = '0;
          err_d   = '0;
          fv_d    = 1'b0;
          fa_d    = '0;
          fb_d    = '0;
        end
      end
      APPLY: begin
        // Hold the vector for SETTLE cycles before sampling
        if (cnt_q == CNT_W'(SETTLE - 1)) begin
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CHECK: begin
        if (mismatch_c) begin
          if (err_q != ERR_MAX) begin
            err_d = err_q + ERR_W'(1);
          end
          // Only the first failure is captured
          if (!fv_q) begin
            fv_d = 1'b1;
            fa_d = a_q;
            fb_d = b_q;
          end
        end
        // Final vector stays on the bus once the sweep ends
        if ((a_q == VEC_MAX) && (b_q == VEC_MAX)) begin
          state_d = DONE;
        end else begin
          state_d = APPLY;
          cnt_d   = '0;
          b_d     = b_q + WIDTH'(1);
          if (b_q == VEC_MAX) begin
            a_d = a_q + WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == APPLY) || (state_d == CHECK);
    done_d = (state_d == DONE);
    pass_d = done_d && (err_d == '0);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      fa_q    <= '0;
      fb_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign adder.a_out = a_q;
  assign adder.b_out = b_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign err_count   = err_q;
  assign fail_valid  = fv_q;
  assign fail_a      = fa_q;
  assign fail_b      = fb_q;

endmodule

// File: tb/tb_brent_kung_sweep.sv
// Self-checking bench for brent_kung_sweep with a behavioural adder model.
module tb_brent_kung_sweep;

  localparam int unsigned WIDTH     = 4;
  localparam int unsigned SETTLE    = 2;
  localparam int          SWEEP_CYC = (1 << (2 * WIDTH)) * (SETTLE + 1);
  localparam int          MAX_WAIT  = 4 * SWEEP_CYC;

  typedef struct {
    logic [7:0]       err;
    logic             fv;
    logic [WIDTH-1:0] fa;
    logic [WIDTH-1:0] fb;
    logic             pass;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic             busy, done, pass, fail_valid;
  logic [7:0]       err_count;
  logic [WIDTH-1:0] fail_a, fail_b;

  int errors = 0;
  int checks = 0;
  int mode   = 0;   // 0 ideal, 1 wrong at (3,1), 2 stuck at 0
  bit inj_en = 1'b0;

  exp_t exp_q[$];

  brent_kung_sweep_if #(.WIDTH(WIDTH)) bus ();

  always #5 clk = ~clk;

  function automatic logic [WIDTH:0] adder_model(input int m, input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (m == 1 && a == 4'd3 && b == 4'd1) s = 5'd3;
    if (m == 2) s = '0;
    return s;
  endfunction

  function automatic bit inj_vec(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return (a == 4'd2 && b == 4'd5) || (a == 4'd7 && b == 4'd7);
  endfunction

  always_comb bus.sum_in = adder_model(mode, bus.a_out, bus.b_out);

`ifdef BRENT_KUNG_SWEEP_INJECT_EN
  logic inject;
  always_comb inject = inj_en && inj_vec(bus.a_out, bus.b_out);
`endif

  brent_kung_sweep #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
`ifdef BRENT_KUNG_SWEEP_INJECT_EN
    .inject     (inject),
`endif
    .adder      (bus.master),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .fail_valid (fail_valid),
    .fail_a     (fail_a),
    .fail_b     (fail_b)
  );

  // Expected sweep outcome from the adder model over every operand pair
  function automatic exp_t model_result(input int m, input bit inj);
    exp_t e;
    logic [WIDTH-1:0] av, bv;
    logic [WIDTH:0]   ref_sum;
    e.err = '0; e.fv = 1'b0; e.fa = '0; e.fb = '0;
    for (int ia = 0; ia < (1 << WIDTH); ia++) begin
      for (int ib = 0; ib < (1 << WIDTH); ib++) begin
        av = WIDTH'(ia);
        bv = WIDTH'(ib);
        ref_sum = (WIDTH + 1)'(ia + ib);
        if (inj && inj_vec(av, bv)) ref_sum[0] = ~ref_sum[0];
        if (adder_model(m, av, bv) != ref_sum) begin
          if (e.err != 8'hFF) e.err = e.err + 8'd1;
          if (!e.fv) begin
            e.fv = 1'b1; e.fa = av; e.fb = bv;
          end
        end
      end
    end
    e.pass = (e.err == 8'd0);
    return e;
  endfunction

  // Pulse start, optionally re-pulse mid-sweep, then compare outcome with the scoreboard
  task automatic run_sweep(input string name, input int restart_at);
    exp_t e;
    int cyc;
    int waited;
    exp_q.push_back(model_result(mode, inj_en));
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    checks++;
    if ({busy, done, err_count, fail_valid, bus.a_out, bus.b_out} !== {1'b1, 1'b0, 8'd0, 1'b0, 4'd0, 4'd0})
      begin
      errors++;
      $display("FAIL %s first_vector: busy=%b done=%b err=%0d fv=%b a=%0d b=%0d, want 1 0 0 0 0 0",
               name, busy, done, err_count, fail_valid, bus.a_out, bus.b_out);
    end
    cyc = 1;
    waited = 0;
    while (!done && waited < MAX_WAIT) begin
      start = (cyc == restart_at);
      @(negedge clk);
      waited++;
      if (busy) cyc++;
    end
    start = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout: done not seen after %0d cycles", name, waited);
      return;
    end
    checks++;
    if (cyc !== SWEEP_CYC) begin
      errors++;
      $display("FAIL %s busy_len: got %0d want %0d", name, cyc, SWEEP_CYC);
    end
    checks++;
    if (err_count !== e.err) begin
      errors++;
      $display("FAIL %s err_count: got %0d want %0d", name, err_count, e.err);
    end
    checks++;
    if ({fail_valid, fail_a, fail_b} !== {e.fv, e.fa, e.fb}) begin
      errors++;
      $display("FAIL %s fail_capture: got fv=%b a=%0d b=%0d want fv=%b a=%0d b=%0d",
               name, fail_valid, fail_a, fail_b, e.fv, e.fa, e.fb);
    end
    checks++;
    if ({pass, busy} !== {e.pass, 1'b0}) begin
      errors++;
      $display("FAIL %s pass_busy: got pass=%b busy=%b want pass=%b busy=0", name, pass, busy, e.pass);
    end
    checks++;
    if ({bus.a_out, bus.b_out} !== {4'd15, 4'd15}) begin
      errors++;
      $display("FAIL %s last_vector: got a=%0d b=%0d want 15 15", name, bus.a_out, bus.b_out);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({bus.a_out, bus.b_out, busy, done, pass, err_count, fail_valid, fail_a, fail_b} !== '0) begin
      errors++;
      $display("FAIL %s outputs_zero: a=%0d b=%0d busy=%b done=%b pass=%b err=%0d fv=%b fa=%0d fb=%0d want all 0",
               name, bus.a_out, bus.b_out, busy, done, pass, err_count, fail_valid, fail_a, fail_b);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("idle");
  endtask

  task automatic test_ideal();
    mode = 0;
    run_sweep("ideal", -1);
    checks++;
    if (bus.sum_in !== 5'd30) begin
      errors++;
      $display("FAIL ideal final_sum: got %0d want 30", bus.sum_in);
    end
    checks++;
    if ({done, pass, err_count} !== {1'b1, 1'b1, 8'd0}) begin
      errors++;
      $display("FAIL ideal done_pass: got done=%b pass=%b err=%0d want 1 1 0", done, pass, err_count);
    end
  endtask

  task automatic test_single_fault();
    mode = 1;
    run_sweep("fault_3_1", -1);
  endtask

  task automatic test_stuck_zero();
    mode = 2;
    run_sweep("stuck0", -1);
    checks++;
    if ({err_count, fail_a, fail_b} !== {8'd255, 4'd0, 4'd1}) begin
      errors++;
      $display("FAIL stuck0 saturate: got err=%0d fa=%0d fb=%0d want 255 0 1", err_count, fail_a, fail_b);
    end
  endtask

  // Sweep started from DONE with prior errors must clear and restart from (0,0)
  task automatic test_back_to_back();
    mode = 0;
    run_sweep("restart_from_done", -1);
  endtask

  task automatic test_start_ignored();
    mode = 0;
    run_sweep("start_mid_sweep", 300);
  endtask

  task automatic test_reset_mid();
    int n;
    mode = 2;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 1;
    while (n < 100) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("reset_mid");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset_mid_idle");
    mode = 0;
    run_sweep("after_reset", -1);
  endtask

  task automatic test_inject();
`ifdef BRENT_KUNG_SWEEP_INJECT_EN
    mode = 0;
    inj_en = 1'b1;
    run_sweep("inject", -1);
    checks++;
    if ({err_count, fail_a, fail_b} !== {8'd2, 4'd2, 4'd5}) begin
      errors++;
      $display("FAIL inject capture: got err=%0d fa=%0d fb=%0d want 2 2 5", err_count, fail_a, fail_b);
    end
    inj_en = 1'b0;
`endif
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    test_reset();
    test_ideal();
    test_single_fault();
    test_stuck_zero();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid();
    test_inject();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/brent_kung_sweep.md
# brent_kung_sweep

On-chip stimulus generator and response checker for the `brent_kung` adder: the producing/consuming end of the operand/sum interface. On `start` it drives every operand pair (a, b) onto the adder inputs, waits a fixed settle time, samples the adder's sum/carry output, and compares it against an internally computed a+b. It reports an error count, the first failing operand pair and a pass flag, so the adder can be verified after tapeout without an external bench.

## Interface
- `WIDTH`, 4: operand width. The sum is WIDTH+1 bits.
- `SETTLE`, 2: number of cycles from driving a vector to sampling its sum. Legal range is 1..15.
- `clk` in 1: the only clock. All state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: level-sampled request to begin a sweep.
- `a_out` out WIDTH: operand a, to the adder (`ui_in[WIDTH-1:0]`).
- `b_out` out WIDTH: operand b, to the adder (`uio_in[WIDTH-1:0]`).
- `sum_in` in WIDTH+1: adder result (`uo_out[WIDTH:0]`).
- `busy` out 1: a sweep is in progress.
- `done` out 1: the sweep has completed. Holds until the next start or reset.
- `pass` out 1: equals `done` && `err_count`==0.
- `err_count` out 8: number of mismatches. Saturates at 255.
- `fail_valid` out 1: `fail_a`/`fail_b` hold a captured failure.
- `fail_a`, `fail_b` out WIDTH each: operands of the first mismatch.

## Operation
- States: IDLE, APPLY, CHECK, DONE.
- IDLE:
  - `busy`=0, `done`=0.
  - `start`=1 goes to APPLY.
  - On that transition: a=0, b=0, settle counter=0, `err_count`=0, `fail_valid`=0.
- APPLY:
  - `a_out`/`b_out` are held stable.
  - The settle counter increments each cycle.
  - When the counter reaches SETTLE-1, go to CHECK.
- CHECK (one cycle):
  - Compare `sum_in` with the expected value {1'b0,a}+{1'b0,b}, computed WIDTH+1 bits wide with no truncation.
  - On mismatch: `err_count`+1 (saturating at 255).
  - If `fail_valid`=0, capture a, b into `fail_a`/`fail_b` and set `fail_valid`=1. Later mismatches do not overwrite the capture.
  - Then advance b. When b wraps from 2^WIDTH-1 to 0, advance a.
  - If a=b=2^WIDTH-1 was just checked, go to DONE. Otherwise return to APPLY with the counter cleared.
- DONE:
  - `done`=1, `busy`=0. `a_out`/`b_out` hold the last vector.
  - `start`=1 restarts exactly as from IDLE, clearing all results.
- `start` is ignored while `busy`=1.
- `rst` asserted in any state, including mid-sweep:
  - Next state is IDLE.
  - All outputs reset to 0: `a_out`, `b_out`, `busy`, `done`, `pass`, `err_count`, `fail_valid`, `fail_a`, `fail_b`.

## Timing
- Cycle 0: `start` sampled high in IDLE. From edge 1: `busy`=1 and vector (0,0) is driven.
- Each vector occupies SETTLE+1 cycles: SETTLE in APPLY, then 1 in CHECK.
- `sum_in` is sampled at the CHECK edge, which is SETTLE cycles after the vector changed.
- Full sweep is 2^(2·WIDTH)·(SETTLE+1) cycles. For defaults: 256·3 = 768 cycles.
- `done` rises on the edge after the final CHECK. `busy` falls on the same edge.
- `err_count` and the fail capture update on the edge that ends CHECK. They are visible in the following cycle.
- Outputs are registered. There is no combinational path from `sum_in` to any output.

## Configuration
- Macro `BRENT_KUNG_SWEEP_INJECT_EN`.
- When defined:
  - Adds input port `inject` (1 bit).
  - When `inject`=1 during CHECK, the expected value has bit 0 inverted, forcing a mismatch. This self-tests the checker.
- When undefined:
  - The port is absent.
  - The comparison uses the true expected value.
  - Behaviour is otherwise identical.

## Test plan
- Ideal adder model on `sum_in`, defaults, `start` pulsed once:
  - `busy` is high for 768 cycles.
  - Then `done`=1, `pass`=1, `err_count`=0, `fail_valid`=0.
  - Last driven vector is a=15, b=15; the model returns 30.
- Model forced wrong when a=3, b=1 (returns 3 instead of 4):
  - Sweep ends with `err_count`=1, `fail_valid`=1, `fail_a`=3, `fail_b`=1, `pass`=0.
- `sum_in` stuck at 0:
  - `err_count`=255 (saturated, of 255 true mismatches).
  - `fail_a`=0, `fail_b`=1 (first non-zero sum).
- `rst` asserted at cycle 100 of a sweep:
  - Next cycle all outputs are 0 and the state is IDLE.
  - A new `start` then completes in 768 cycles with `pass`=1.
- `start` re-asserted mid-sweep is ignored; total sweep length stays 768. `start` asserted in DONE clears `done`/`err_count` and restarts the sweep from (0,0).
- With `BRENT_KUNG_SWEEP_INJECT_EN` defined, ideal model, and `inject`=1 for the vectors (2,5) and (7,7):
  - `err_count`=2, `fail_a`=2, `fail_b`=5.
